// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_pkg
// Description : Shared types and flag indices for the arbitrated ALU block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_SHL = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAG_W = 4;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
//------------------------------------------------------------------------------
// Module      : alu_core
// Description : Combinational N-bit SUB/AND/XOR/SHL unit producing {N,Z,C,V}.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [1:0]        i_op,
    input  logic [N-1:0]      i_a,
    input  logic [N-1:0]      i_b,
    output logic [N-1:0]      o_result,
    output logic [FLAG_W-1:0] o_flags
);

    alu_op_t        w_op;
    logic [N:0]     w_diff;
    logic [N:0]     w_shl;
    logic [N-1:0]   w_result;
    logic           w_carry;
    logic           w_ovf;

    assign w_op   = alu_op_t'(i_op);
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Widening by one bit lets bit N catch A[N-B] for 1<=B<=N, and zero otherwise.
    assign w_shl  = {1'b0, i_a} << i_b;

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_op)
            OP_SUB: begin
                w_result = w_diff[N-1:0];
                w_carry  = w_diff[N];
                w_ovf    = (i_a[N-1] ^ i_b[N-1]) & (w_diff[N-1] ^ i_a[N-1]);
            end
            OP_AND: begin
                w_result = i_a & i_b;
            end
            OP_XOR: begin
                w_result = i_a ^ i_b;
            end
            OP_SHL: begin
                w_result = w_shl[N-1:0];
                w_carry  = w_shl[N];
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    always_comb begin
        o_result         = w_result;
        o_flags          = '0;
        o_flags[FLAG_N]  = w_result[N-1];
        o_flags[FLAG_Z]  = (w_result == '0);
        o_flags[FLAG_C]  = w_carry;
        o_flags[FLAG_V]  = w_ovf;
    end

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
//------------------------------------------------------------------------------
// Module      : alu_req_arbiter
// Description : Two-requester round-robin arbiter sequencing a shared ALU core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int N = 6
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req1_b,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [N-1:0]  rsp_result,
    output logic [3:0]    rsp_flags
);

    state_t             r_state;
    state_t             w_next_state;

    logic               r_ptr;
    logic [1:0]         r_op;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic               r_id;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [N-1:0]       r_rsp_result;
    logic [FLAG_W-1:0]  r_rsp_flags;

    logic               w_any_valid;
    logic               w_sel;
    logic               w_accept;
    logic [N-1:0]       w_core_result;
    logic [FLAG_W-1:0]  w_core_flags;

    // Contention resolves to the pointer; otherwise whichever side is asking.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_sel       = (req0_valid & req1_valid) ? r_ptr : req1_valid;
    assign w_accept    = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    alu_core #(
        .N (N)
    ) u_alu_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_core_result),
        .o_flags  (w_core_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = EXEC;
            EXEC:                   w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((r_state == IDLE) && !rst && w_any_valid) begin
            if (w_sel) begin
                req1_ready = 1'b1;
            end else begin
                req0_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= w_sel ? req1_op : req0_op;
                r_a   <= w_sel ? req1_a  : req0_a;
                r_b   <= w_sel ? req1_b  : req0_b;
                r_id  <= w_sel;
                r_ptr <= ~w_sel;
            end
            if (r_state == EXEC) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_id;
                r_rsp_result <= w_core_result;
                r_rsp_flags  <= w_core_flags;
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_req_arbiter
// Description : Directed self-checking bench for alu_req_arbiter (N = 6).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_req_arbiter;

    localparam int N = 6;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [1:0]    req0_op;
    logic [N-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [1:0]    req1_op;
    logic [N-1:0]  req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0]  rsp_result;
    logic [3:0]    rsp_flags;

    int n_checks = 0;
    int n_errors = 0;

    alu_req_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with rsp_ready held high: accept, EXEC, RESP, handshake.
    task automatic run_op(input string tag, input logic id, input logic [1:0] op,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_res, input logic [3:0] exp_flags);
        int k;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 8) begin
            step();
            k++;
        end
        chk({tag, "_ready"}, {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        step();
        chk({tag, "_valid"},  {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_result"}, {26'd0, rsp_result}, {26'd0, exp_res});
        chk({tag, "_flags"},  {28'd0, rsp_flags}, {28'd0, exp_flags});
        chk({tag, "_id"},     {31'd0, rsp_id}, {31'd0, id});
        step();
        chk({tag, "_done"},   {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("rst_result", {26'd0, rsp_result}, 32'd0);
        chk("rst_flags",  {28'd0, rsp_flags}, 32'd0);
        chk("rst_id",     {31'd0, rsp_id}, 32'd0);
        chk("rst_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);

        // SHL including the B = N and B > N boundaries
        run_op("shl1", 1'b0, 2'd3, 6'b001100, 6'd2, 6'b110000, 4'b1000);
        run_op("shl2", 1'b1, 2'd3, 6'b111000, 6'd2, 6'b100000, 4'b1010);
        run_op("shl3", 1'b1, 2'd3, 6'b000011, 6'd3, 6'b011000, 4'b0000);
        run_op("shl4", 1'b0, 2'd3, 6'b000011, 6'd7, 6'b000000, 4'b0100);
        run_op("shl5", 1'b1, 2'd3, 6'b000011, 6'd6, 6'b000000, 4'b0110);

        // SUB, AND, XOR
        run_op("sub1", 1'b0, 2'd0, 6'b001100, 6'b000010, 6'b001010, 4'b0000);
        run_op("sub2", 1'b1, 2'd0, 6'b000010, 6'b000011, 6'b111111, 4'b1010);
        run_op("sub3", 1'b0, 2'd0, 6'b100000, 6'b000001, 6'b011111, 4'b0001);
        run_op("and1", 1'b1, 2'd1, 6'b101100, 6'b011010, 6'b001000, 4'b0000);
        run_op("xor1", 1'b0, 2'd2, 6'b101010, 6'b101010, 6'b000000, 4'b0100);
        run_op("xor2", 1'b1, 2'd2, 6'b110000, 6'b001111, 6'b111111, 4'b1000);

        // Fairness from a fresh reset: grants alternate starting with req0
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 6'h3F; req0_b = 6'h15;
        req1_valid = 1'b1; req1_op = 2'd2; req1_a = 6'h3F; req1_b = 6'h15;
        rsp_ready  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!(req0_ready | req1_ready) && k < 8) begin
                step();
                k++;
            end
            chk("rr_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            step();
            step();
            chk("rr_valid",  {31'd0, rsp_valid}, 32'd1);
            chk("rr_id",     {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_result", {26'd0, rsp_result}, (i % 2 == 0) ? 32'h15 : 32'h2A);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;

        // Backpressure: both requesters waiting, response stalled for 5 cycles
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 6'b100000; req0_b = 6'b000001;
        req1_valid = 1'b1; req1_op = 2'd1; req1_a = 6'h3F; req1_b = 6'h3F;
        #1;
        chk("bp_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  {31'd0, rsp_valid}, 32'd1);
            chk("bp_result", {26'd0, rsp_result}, 32'h1F);
            chk("bp_flags",  {28'd0, rsp_flags}, 32'd1);
            chk("bp_id",     {31'd0, rsp_id}, 32'd0);
            chk("bp_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        chk("hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hs_idle",  {30'd0, req1_ready, req0_ready}, 32'd2);

        // Reset during EXEC discards the operation and clears the pointer
        req1_valid = 1'b0;
        #1;
        chk("pre_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        step();
        rst = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        chk("xrst_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("xrst_result", {26'd0, rsp_result}, 32'd0);
        chk("xrst_flags",  {28'd0, rsp_flags}, 32'd0);
        chk("xrst_id",     {31'd0, rsp_id}, 32'd0);
        chk("xrst_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("post_exec_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("post_valid",  {31'd0, rsp_valid}, 32'd1);
        chk("post_id",     {31'd0, rsp_id}, 32'd0);
        chk("post_result", {26'd0, rsp_result}, 32'h1F);
        step();
        chk("post_done",   {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
